grid_seq: RTL and testbench
===========================

GRID_SEQ -- requirements
Module: grid_seq

Interface
REQ-001 SHALL have parameter GRID_ORD, default 3, meaning block order; derived localparams GRID_LEN=GRID_ORD^2, GRID_AREA=GRID_LEN^2, IDX_W=$clog2(GRID_AREA).
REQ-002 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  begin solve; accepted only in IDLE.
REQ-005 SHALL have port clear  in  1  wipe all cells, givens, masks; accepted in IDLE, DONE_OK, DONE_FAIL.
REQ-006 SHALL have ports load_valid in 1, load_index in IDX_W, load_value in GRID_LEN: write a one-hot given; 0 removes a given.
REQ-007 SHALL have port load_ready  out  1  high only in IDLE.
REQ-008 SHALL have port load_reject  out  1  one-cycle pulse when a load is refused.
REQ-009 SHALL have ports rd_index in IDX_W and rd_value out GRID_LEN: readout of the one-hot cell value.
REQ-010 SHALL have ports busy, done_success, done_failure  out  1 each.

Function
REQ-011 SHALL encode cell values as one-hot GRID_LEN bits, all-zero = empty.
REQ-012 SHALL hold per-row, per-column, per-block occupancy mask registers, updated incrementally in the same cycle as any cell write or clear; block index = (r/GRID_ORD)*GRID_ORD + c/GRID_ORD.
REQ-013 SHALL implement FSM states IDLE, STEP, BACK, DONE_OK, DONE_FAIL.
REQ-014 IDLE: a load with load_valid&load_ready SHALL write the cell, set its given flag, and update masks next cycle.
REQ-015 A nonzero load SHALL be rejected (no state change, load_reject pulse) if the value is not one-hot, hits row|col|blk occupancy, or targets a cell already holding a given.
REQ-016 A zero load SHALL clear that cell and its given flag and remove its bit from masks; never rejected.
REQ-017 Load and start in the same cycle: load SHALL take effect, start SHALL be ignored.
REQ-018 start in IDLE SHALL set pointer=0 and enter STEP next cycle; busy high in STEP and BACK only.
REQ-019 STEP on a given cell SHALL advance the pointer one cell per cycle without modification.
REQ-020 STEP on a non-given cell SHALL pick the lowest candidate bit strictly above its current value and not in (row|col|blk)&~current.
REQ-021 Candidate found: write it, update masks, advance pointer; if pointer was GRID_AREA-1, enter DONE_OK instead.
REQ-022 No candidate: clear the cell, remove its bit from masks, enter BACK.
REQ-023 BACK SHALL decrement the pointer one cell per cycle past given cells; on a non-given cell enter STEP; decrementing below 0 enters DONE_FAIL.
REQ-024 Last cell given during STEP SHALL enter DONE_OK; first cell given during BACK SHALL enter DONE_FAIL.
REQ-025 done_success/done_failure SHALL be level outputs of DONE_OK/DONE_FAIL, held until clear or reset.
REQ-026 clear SHALL zero all cells, given flags and masks in one cycle and enter IDLE; clear in STEP/BACK SHALL be ignored.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 rd_value SHALL equal the cell at rd_index registered one cycle earlier, valid in every state.
REQ-029 In DONE_FAIL all non-given cells SHALL read zero; in DONE_OK the grid SHALL be a valid solution containing all givens.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, pointer 0, all cells, given flags, masks zero, rd_value 0, all status outputs 0, load_ready 1 after release.
REQ-031 reset asserted mid-solve SHALL abandon the search with no residual state.

Structure
REQ-032 SHALL place the state enum, one-hot helpers (lowest-set-bit-above, is-one-hot) and blockof function in shared package grid_pkg.
REQ-033 SHALL instantiate one sub-module, cand_pick (combinational next-candidate selector); masks and FSM reside in grid_seq.

Verification
REQ-034 ORD=2, no givens, start -> done_success; row 0 reads 0001,0010,0100,1000; every row/col/block one-hot OR = 1111.
REQ-035 ORD=2, load cell0=0001 then cell3=0001 -> second load_reject pulse, cell3 reads 0000.
REQ-036 ORD=2, givens cell0=0001, cell1=0010, cell6=0100, start -> done_failure; cells 2,3,4,5,7..15 read 0000; givens intact.
REQ-037 ORD=3 solvable puzzle loaded, reset pulsed low mid-STEP -> all outputs 0, all cells 0, load_ready 1.
REQ-038 start pulsed during STEP, and clear during BACK -> no effect; solve completes with same result as undisturbed run.
REQ-039 rd_index changed each cycle in DONE_OK -> rd_value tracks with exactly one-cycle latency.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types and one-hot helpers for the backtracking grid solver.
package grid_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StBack,
        StDoneOk,
        StDoneFail
    } state_e;

    // Helpers work on a fixed wide vector; callers zero-extend and truncate.
    localparam int unsigned MAX_LEN = 32;

    // Lowest bit strictly above the set bit of cur (any bit if cur is empty) and not blocked.
    function automatic logic [MAX_LEN-1:0] lowest_above(input logic [MAX_LEN-1:0] cur,
                                                        input logic [MAX_LEN-1:0] blocked);
        logic [MAX_LEN-1:0] res;
        logic               seen;
        res  = '0;
        seen = (cur == '0);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (seen && !blocked[i] && (res == '0)) res[i] = 1'b1;
            if (cur[i]) seen = 1'b1;
        end
        return res;
    endfunction

    function automatic logic is_one_hot(input logic [MAX_LEN-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic int unsigned blockof(input int unsigned r, input int unsigned c,
                                            input int unsigned ord);
        return (r / ord) * ord + c / ord;
    endfunction

endpackage

// File: rtl/grid_seq_cand_pick.sv
// Next-candidate selector: lowest legal value strictly above the cell's current value.
module cand_pick
    import grid_pkg::*;
#(
    parameter int unsigned GRID_LEN = 9
) (
    input  logic [GRID_LEN-1:0] cur,
    input  logic [GRID_LEN-1:0] occ,
    output logic [GRID_LEN-1:0] cand,
    output logic                found
);

    // The cell's own bit is in occ, so it must not block itself.
    always_comb begin
        cand  = GRID_LEN'(lowest_above(MAX_LEN'(cur), MAX_LEN'(occ & ~cur)));
        found = |cand;
    end

endmodule

// File: rtl/grid_seq.sv
// Sudoku-style grid loader and chronological backtracking solver with
// incrementally maintained row/column/block occupancy masks.
module grid_seq
    import grid_pkg::*;
#(
    parameter  int unsigned GRID_ORD  = 3,
    localparam int unsigned GRID_LEN  = GRID_ORD * GRID_ORD,
    localparam int unsigned GRID_AREA = GRID_LEN * GRID_LEN,
    localparam int unsigned IDX_W     = $clog2(GRID_AREA)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic                load_valid,
    input  logic [IDX_W-1:0]    load_index,
    input  logic [GRID_LEN-1:0] load_value,
    output logic                load_ready,
    output logic                load_reject,
    input  logic [IDX_W-1:0]    rd_index,
    output logic [GRID_LEN-1:0] rd_value,
    output logic                busy,
    output logic                done_success,
    output logic                done_failure
);

    localparam int unsigned      LEN_W = $clog2(GRID_LEN);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(GRID_AREA - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, ptr_prev;
    logic [GRID_LEN-1:0]  cells_q [GRID_AREA];
    logic [GRID_AREA-1:0] given_q;
    logic [GRID_LEN-1:0]  row_m_q [GRID_LEN];
    logic [GRID_LEN-1:0]  col_m_q [GRID_LEN];
    logic [GRID_LEN-1:0]  blk_m_q [GRID_LEN];
    logic [GRID_LEN-1:0]  rd_value_q;
    logic                 reject_q, reject_d;

    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_ok;
    logic [LEN_W-1:0]     sel_r, sel_c, sel_b;
    logic [GRID_LEN-1:0]  sel_cur, sel_occ, cand;
    logic                 cand_found;
    logic                 wr_en, set_given, clr_given, clear_all;
    logic [GRID_LEN-1:0]  wr_val;

    // One cell is touched per cycle: the load target in IDLE, else the search pointer.
    always_comb begin
        sel_idx = (state_q == StIdle) ? load_index : ptr_q;
        sel_ok  = 32'(sel_idx) < GRID_AREA;
        sel_r   = LEN_W'(32'(sel_idx) / GRID_LEN);
        sel_c   = LEN_W'(32'(sel_idx) % GRID_LEN);
        sel_b   = LEN_W'(blockof(32'(sel_r), 32'(sel_c), GRID_ORD));
        sel_cur = sel_ok ? cells_q[sel_idx] : '0;
        sel_occ = sel_ok ? (row_m_q[sel_r] | col_m_q[sel_c] | blk_m_q[sel_b]) : '0;
    end

    cand_pick #(
        .GRID_LEN(GRID_LEN)
    ) u_cand_pick (
        .cur  (sel_cur),
        .occ  (sel_occ),
        .cand (cand),
        .found(cand_found)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ptr_prev  = ptr_q - 1'b1;
        wr_en     = 1'b0;
        wr_val    = '0;
        set_given = 1'b0;
        clr_given = 1'b0;
        clear_all = 1'b0;
        reject_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    clear_all = 1'b1;
                end else if (load_valid) begin
                    if (load_value == '0) begin
                        wr_en     = sel_ok;
                        clr_given = sel_ok;
                    end else if (sel_ok && is_one_hot(MAX_LEN'(load_value)) &&
                                 ((sel_occ & load_value) == '0) && !given_q[sel_idx]) begin
                        wr_en     = 1'b1;
                        wr_val    = load_value;
                        set_given = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (start) begin
                    ptr_d   = '0;
                    state_d = StStep;
                end
            end
            StStep: begin
                if (given_q[ptr_q] || cand_found) begin
                    if (!given_q[ptr_q]) begin
                        wr_en  = 1'b1;
                        wr_val = cand;
                    end
                    if (ptr_q == LAST) state_d = StDoneOk;
                    else               ptr_d   = ptr_q + 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    state_d = StBack;
                end
            end
            StBack: begin
                if (ptr_q == '0) begin
                    state_d = StDoneFail;
                end else begin
                    ptr_d = ptr_prev;
                    if (!given_q[ptr_prev]) state_d = StStep;
                end
            end
            StDoneOk, StDoneFail: begin
                if (clear) begin
                    clear_all = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            given_q    <= '0;
            rd_value_q <= '0;
            reject_q   <= 1'b0;
            for (int i = 0; i < GRID_AREA; i++) cells_q[i] <= '0;
            for (int i = 0; i < GRID_LEN; i++) begin
                row_m_q[i] <= '0;
                col_m_q[i] <= '0;
                blk_m_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            reject_q   <= reject_d;
            rd_value_q <= (32'(rd_index) < GRID_AREA) ? cells_q[rd_index] : '0;
            if (clear_all) begin
                given_q <= '0;
                for (int i = 0; i < GRID_AREA; i++) cells_q[i] <= '0;
                for (int i = 0; i < GRID_LEN; i++) begin
                    row_m_q[i] <= '0;
                    col_m_q[i] <= '0;
                    blk_m_q[i] <= '0;
                end
            end else if (wr_en) begin
                cells_q[sel_idx] <= wr_val;
                row_m_q[sel_r]   <= (row_m_q[sel_r] & ~sel_cur) | wr_val;
                col_m_q[sel_c]   <= (col_m_q[sel_c] & ~sel_cur) | wr_val;
                blk_m_q[sel_b]   <= (blk_m_q[sel_b] & ~sel_cur) | wr_val;
                if (set_given) given_q[sel_idx] <= 1'b1;
                if (clr_given) given_q[sel_idx] <= 1'b0;
            end
        end
    end

    assign load_ready   = (state_q == StIdle);
    assign load_reject  = reject_q;
    assign rd_value     = rd_value_q;
    assign busy         = (state_q == StStep) || (state_q == StBack);
    assign done_success = (state_q == StDoneOk);
    assign done_failure = (state_q == StDoneFail);

endmodule

// File: tb/tb_grid_seq.sv
// Bench for grid_seq: ORD=2 instance against a digit-level backtracking model,
// plus an ORD=3 instance for the mid-solve reset scenario.
module tb_grid_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       rst2, start2, clear2, lv2, ready2, rej2, busy2, ok2, fail2;
    logic [3:0] li2, lval2, rdi2, rdv2;

    grid_seq #(.GRID_ORD(2)) dut2 (
        .clock(clk), .reset(rst2), .start(start2), .clear(clear2),
        .load_valid(lv2), .load_index(li2), .load_value(lval2),
        .load_ready(ready2), .load_reject(rej2), .rd_index(rdi2), .rd_value(rdv2),
        .busy(busy2), .done_success(ok2), .done_failure(fail2)
    );

    logic       rst3, start3, clear3, lv3, ready3, rej3, busy3, ok3, fail3;
    logic [6:0] li3, rdi3;
    logic [8:0] lval3, rdv3;

    grid_seq #(.GRID_ORD(3)) dut3 (
        .clock(clk), .reset(rst3), .start(start3), .clear(clear3),
        .load_valid(lv3), .load_index(li3), .load_value(lval3),
        .load_ready(ready3), .load_reject(rej3), .rd_index(rdi3), .rd_value(rdv3),
        .busy(busy3), .done_success(ok3), .done_failure(fail3)
    );

    // Model: digits 0..4 per cell (0 = empty).
    int         m_val[16];
    bit         m_giv[16];
    int         m_sol[16];
    bit         m_ok;
    logic [3:0] got2[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int d);
        return (d == 0) ? 4'd0 : 4'(1 << (d - 1));
    endfunction

    function automatic bit clash(input int g[16], input int i, input int d);
        for (int j = 0; j < 16; j++)
            if (j != i && g[j] == d && (j / 4 == i / 4 || j % 4 == i % 4 ||
                (j / 8 == i / 8 && (j % 4) / 2 == (i % 4) / 2)))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_load(input int idx, input logic [3:0] v);
        int d;
        if (v == 4'd0) begin
            m_val[idx] = 0;
            m_giv[idx] = 1'b0;
            return 1'b0;
        end
        if ($countones(v) != 1 || m_giv[idx]) return 1'b1;
        d = $clog2(v) + 1;
        if (clash(m_val, idx, d)) return 1'b1;
        m_val[idx] = d;
        m_giv[idx] = 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < 16; k++) begin
            m_val[k] = 0;
            m_giv[k] = 1'b0;
        end
    endfunction

    // Depth-first search: cells in order, values ascending -> first solution found.
    function automatic void m_solve();
        int i   = 0;
        int dir = 1;
        bit found;
        m_sol = m_val;
        while (i >= 0 && i < 16) begin
            if (m_giv[i]) begin
                i += dir;
            end else begin
                found = 1'b0;
                for (int d = m_sol[i] + 1; d <= 4; d++)
                    if (!found && !clash(m_sol, i, d)) begin
                        m_sol[i] = d;
                        found    = 1'b1;
                    end
                if (found) begin
                    dir = 1;
                    i++;
                end else begin
                    m_sol[i] = 0;
                    dir      = -1;
                    i--;
                end
            end
        end
        m_ok = (i == 16);
    endfunction

    task automatic do_clear2();
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        m_clear();
    endtask

    task automatic load2(input int idx, input logic [3:0] v, input string name);
        bit exp;
        exp   = m_load(idx, v);
        lv2   = 1'b1;
        li2   = 4'(idx);
        lval2 = v;
        tick();
        lv2   = 1'b0;
        n_tests++;
        if (rej2 !== exp) begin
            n_fail++;
            $display("FAIL %s reject cell %0d val %b: got %b expected %b", name, idx, v, rej2, exp);
        end
    endtask

    task automatic wait_done2(input string name);
        int n = 0;
        while (!(ok2 || fail2) && n < 20000) begin
            tick();
            n++;
        end
        if (!(ok2 || fail2)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got no done expected done within 20000 cycles", name);
        end
    endtask

    task automatic run2(input string name);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n_tests++;
        if (busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after start: got %b expected 1", name, busy2);
        end
        wait_done2(name);
    endtask

    task automatic check_flags2(input string name);
        m_solve();
        n_tests++;
        if (ok2 !== m_ok || fail2 !== !m_ok || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s flags: got ok=%b fail=%b busy=%b expected ok=%b fail=%b busy=0",
                     name, ok2, fail2, busy2, m_ok, !m_ok);
        end
    endtask

    task automatic check_grid2(input string name);
        for (int k = 0; k < 16; k++) begin
            rdi2 = 4'(k);
            tick();
            got2[k] = rdv2;
            n_tests++;
            if (rdv2 !== oh(m_sol[k])) begin
                n_fail++;
                $display("FAIL %s cell %0d: got %b expected %b", name, k, rdv2, oh(m_sol[k]));
            end
        end
    endtask

    task automatic test_reset();
        rst2 = 1'b0; start2 = 1'b0; clear2 = 1'b0; lv2 = 1'b0; li2 = '0; lval2 = '0; rdi2 = '0;
        rst3 = 1'b0; start3 = 1'b0; clear3 = 1'b0; lv3 = 1'b0; li3 = '0; lval3 = '0; rdi3 = '0;
        m_clear();
        repeat (3) tick();
        rst2 = 1'b1;
        rst3 = 1'b1;
        tick();
        n_tests++;
        if ({ready2, rej2, busy2, ok2, fail2, rdv2} !== {5'b10000, 4'd0}) begin
            n_fail++;
            $display("FAIL reset ord2: got rdy/rej/busy/ok/fail/rd=%b%b%b%b%b/%b expected 10000/0000",
                     ready2, rej2, busy2, ok2, fail2, rdv2);
        end
        n_tests++;
        if ({ready3, rej3, busy3, ok3, fail3} !== 5'b10000 || rdv3 !== 9'd0) begin
            n_fail++;
            $display("FAIL reset ord3: got rdy/rej/busy/ok/fail=%b%b%b%b%b rd=%b expected 10000 rd=0",
                     ready3, rej3, busy3, ok3, fail3, rdv3);
        end
    endtask

    task automatic test_empty_solve();
        logic [3:0] exp_row0[4];
        logic [3:0] orr, orc, orb;
        exp_row0[0] = 4'b0001; exp_row0[1] = 4'b0010; exp_row0[2] = 4'b0100; exp_row0[3] = 4'b1000;
        do_clear2();
        run2("empty");
        check_flags2("empty");
        check_grid2("empty");
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (got2[c] !== exp_row0[c]) begin
                n_fail++;
                $display("FAIL empty row0 col %0d: got %b expected %b", c, got2[c], exp_row0[c]);
            end
        end
        for (int u = 0; u < 4; u++) begin
            orr = '0; orc = '0; orb = '0;
            for (int k = 0; k < 4; k++) begin
                orr |= got2[u * 4 + k];
                orc |= got2[k * 4 + u];
                orb |= got2[(u / 2) * 8 + (u % 2) * 2 + (k / 2) * 4 + (k % 2)];
            end
            n_tests++;
            if ({orr, orc, orb} !== 12'hFFF) begin
                n_fail++;
                $display("FAIL empty unit %0d or: got row=%b col=%b blk=%b expected 1111", u, orr, orc, orb);
            end
        end
    endtask

    task automatic test_load_reject();
        do_clear2();
        load2(0, 4'b0001, "ld_given0");
        load2(3, 4'b0001, "ld_rowclash");
        tick();
        n_tests++;
        if (rej2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reject pulse width: got %b expected 0", rej2);
        end
        rdi2 = 4'd3;
        tick();
        n_tests++;
        if (rdv2 !== 4'b0000) begin
            n_fail++;
            $display("FAIL rejected cell3: got %b expected 0000", rdv2);
        end
        load2(0, 4'b0010, "ld_on_given");
        load2(5, 4'b0011, "ld_not_onehot");
        load2(0, 4'b0000, "ld_zero");
        load2(3, 4'b0001, "ld_after_remove");
        rdi2 = 4'd0;
        tick();
        n_tests++;
        if (rdv2 !== 4'b0000) begin
            n_fail++;
            $display("FAIL removed cell0: got %b expected 0000", rdv2);
        end
        rdi2 = 4'd3;
        tick();
        n_tests++;
        if (rdv2 !== 4'b0001) begin
            n_fail++;
            $display("FAIL reloaded cell3: got %b expected 0001", rdv2);
        end
    endtask

    task automatic test_fail();
        do_clear2();
        load2(0, 4'b0001, "fail_ld0");
        load2(1, 4'b0010, "fail_ld1");
        load2(6, 4'b0100, "fail_ld6");
        run2("fail");
        n_tests++;
        if (fail2 !== 1'b1 || ok2 !== 1'b0) begin
            n_fail++;
            $display("FAIL unsolvable flags: got ok=%b fail=%b expected ok=0 fail=1", ok2, fail2);
        end
        m_solve();
        check_grid2("fail");
    endtask

    task automatic random_loads(input string name);
        int         n;
        int         sel;
        logic [3:0] v;
        n = $urandom_range(8, 3);
        for (int j = 0; j < n; j++) begin
            sel = $urandom_range(3, 0);
            if (sel == 0)      v = 4'd0;
            else if (sel == 3) v = 4'($urandom_range(15, 0));
            else               v = 4'(1 << $urandom_range(3, 0));
            load2($urandom_range(15, 0), v, name);
        end
    endtask

    task automatic test_random();
        int idx;
        for (int r = 0; r < 16; r++) begin
            do_clear2();
            random_loads("rnd_load");
            if (r % 2 == 0) begin
                // Zero load presented together with start: the load wins.
                idx    = $urandom_range(15, 0);
                void'(m_load(idx, 4'd0));
                lv2    = 1'b1;
                li2    = 4'(idx);
                lval2  = 4'd0;
                start2 = 1'b1;
                tick();
                lv2    = 1'b0;
                start2 = 1'b0;
                n_tests++;
                if (busy2 !== 1'b0 || ready2 !== 1'b1 || rej2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_with_start: got busy=%b ready=%b rej=%b expected 0 1 0",
                             busy2, ready2, rej2);
                end
            end
            run2("rnd");
            check_flags2("rnd");
            check_grid2("rnd");
            do_clear2();
            n_tests++;
            if (ready2 !== 1'b1 || ok2 !== 1'b0 || fail2 !== 1'b0) begin
                n_fail++;
                $display("FAIL clear from done: got ready=%b ok=%b fail=%b expected 1 0 0",
                         ready2, ok2, fail2);
            end
        end
    endtask

    task automatic test_disturb();
        int n;
        for (int r = 0; r < 4; r++) begin
            do_clear2();
            random_loads("dist_load");
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            n = 0;
            while (busy2 && n < 20000) begin
                clear2 = 1'($urandom_range(1, 0));
                start2 = 1'($urandom_range(1, 0));
                tick();
                n++;
            end
            clear2 = 1'b0;
            start2 = 1'b0;
            if (busy2) begin
                n_tests++;
                n_fail++;
                $display("FAIL disturb timeout: got busy expected done within 20000 cycles");
            end
            check_flags2("disturb");
            check_grid2("disturb");
        end
    endtask

    task automatic test_rd_latency();
        do_clear2();
        load2(5, 4'b0001, "lat_ld");
        run2("lat");
        check_flags2("lat");
        rdi2 = 4'd0;
        tick();
        for (int k = 1; k < 16; k++) begin
            rdi2 = 4'(k);
            #1;
            n_tests++;
            if (rdv2 !== oh(m_sol[k - 1])) begin
                n_fail++;
                $display("FAIL rd before edge idx %0d: got %b expected %b", k, rdv2, oh(m_sol[k - 1]));
            end
            tick();
            n_tests++;
            if (rdv2 !== oh(m_sol[k])) begin
                n_fail++;
                $display("FAIL rd after edge idx %0d: got %b expected %b", k, rdv2, oh(m_sol[k]));
            end
        end
    endtask

    task automatic test_reset_mid3();
        int         gi[7];
        logic [8:0] gv[7];
        int         nz;
        gi = '{0, 1, 4, 9, 12, 13, 14};
        gv = '{9'd16, 9'd4, 9'd64, 9'd32, 9'd1, 9'd256, 9'd16};
        for (int j = 0; j < 7; j++) begin
            lv3   = 1'b1;
            li3   = 7'(gi[j]);
            lval3 = gv[j];
            tick();
            lv3   = 1'b0;
            n_tests++;
            if (rej3 !== 1'b0) begin
                n_fail++;
                $display("FAIL ord3 load %0d: got reject %b expected 0", j, rej3);
            end
        end
        rdi3   = 7'd0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (20) tick();
        n_tests++;
        if (busy3 !== 1'b1) begin
            n_fail++;
            $display("FAIL ord3 mid-solve busy: got %b expected 1", busy3);
        end
        #2;
        rst3 = 1'b0;
        #1;
        n_tests++;
        if ({ready3, rej3, busy3, ok3, fail3} !== 5'b10000 || rdv3 !== 9'd0) begin
            n_fail++;
            $display("FAIL ord3 async reset: got rdy/rej/busy/ok/fail=%b%b%b%b%b rd=%b expected 10000 rd=0",
                     ready3, rej3, busy3, ok3, fail3, rdv3);
        end
        tick();
        rst3 = 1'b1;
        nz = 0;
        for (int k = 0; k < 81; k++) begin
            rdi3 = 7'(k);
            tick();
            if (rdv3 !== 9'd0) nz++;
        end
        n_tests++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL ord3 cells after reset: got %0d nonzero cells expected 0", nz);
        end
        n_tests++;
        if (ready3 !== 1'b1 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL ord3 after release: got ready=%b busy=%b expected 1 0", ready3, busy3);
        end
    endtask

    initial begin
        test_reset();
        test_empty_solve();
        test_load_reject();
        test_fail();
        test_random();
        test_disturb();
        test_rd_latency();
        test_reset_mid3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
